// File: rtl/dispatch_queue.sv
// dispatch_queue: DEPTH-entry in-order dispatch FIFO between decode/register-read
// and the RS/LSB/ROB. Stored operands snoop NUM_CDB result broadcast channels.
// The head is dispatched into registered outputs with same-cycle CDB forwarding.
// Optional build macro DISPATCH_STALL_CNT_EN adds the stall_cnt/dispatch_cnt counters.
module dispatch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_CDB  = 2,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OPNUM_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OPNUM_W-1:0]           in_opnum,
  input  logic [4:0]                   in_rd,
  input  logic [DATA_W-1:0]            in_imm,
  input  logic [DATA_W-1:0]            in_pc,
  input  logic [DATA_W-1:0]            in_rollback_pc,
  input  logic                         in_is_jump,
  input  logic                         in_is_ls,
  input  logic                         in_pred_jump,
  input  logic [ROB_ID_W-1:0]          in_Q1,
  input  logic [ROB_ID_W-1:0]          in_Q2,
  input  logic [DATA_W-1:0]            in_V1,
  input  logic [DATA_W-1:0]            in_V2,
  input  logic [ROB_ID_W-1:0]          in_rob_id,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id,
  input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
  input  logic                         rob_full,
  input  logic                         rs_full,
  input  logic                         ls_full,
  input  logic                         rollback,
  output logic                         rob_en,
  output logic                         reg_en,
  output logic                         rs_en,
  output logic                         ls_en,
  output logic [OPNUM_W-1:0]           out_opnum,
  output logic [4:0]                   out_rd,
  output logic [DATA_W-1:0]            out_imm,
  output logic [DATA_W-1:0]            out_pc,
  output logic [DATA_W-1:0]            out_rollback_pc,
  output logic                         out_is_jump,
  output logic                         out_pred_jump,
  output logic [ROB_ID_W-1:0]          out_Q1,
  output logic [ROB_ID_W-1:0]          out_Q2,
  output logic [DATA_W-1:0]            out_V1,
  output logic [DATA_W-1:0]            out_V2,
`ifdef DISPATCH_STALL_CNT_EN
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  dispatch_cnt,
`endif
  output logic [ROB_ID_W-1:0]          out_rob_id
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [OPNUM_W-1:0]  opnum;
    logic [4:0]          rd;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   rollback_pc;
    logic                is_jump;
    logic                is_ls;
    logic                pred_jump;
    logic [ROB_ID_W-1:0] q1;
    logic [ROB_ID_W-1:0] q2;
    logic [DATA_W-1:0]   v1;
    logic [DATA_W-1:0]   v2;
  } entry_t;

  typedef struct packed {
    logic [OPNUM_W-1:0]  opnum;
    logic [4:0]          rd;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   rollback_pc;
    logic                is_jump;
    logic                pred_jump;
    logic [ROB_ID_W-1:0] q1;
    logic [ROB_ID_W-1:0] q2;
    logic [DATA_W-1:0]   v1;
    logic [DATA_W-1:0]   v2;
    logic [ROB_ID_W-1:0] rob_id;
  } out_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  out_t               out_q, out_d;
  logic [3:0]         strb_q, strb_d;   // {rob, reg, rs, ls}

  entry_t             head_e;
  entry_t             new_e;
  logic               disp_go;
  logic               enq_go;

  // Resolve one operand against the broadcast channels; lowest matching channel wins.
  function automatic logic [ROB_ID_W+DATA_W-1:0] snoop(
    input logic [ROB_ID_W-1:0]         q,
    input logic [DATA_W-1:0]           v,
    input logic [NUM_CDB-1:0]          vld,
    input logic [NUM_CDB*ROB_ID_W-1:0] ids,
    input logic [NUM_CDB*DATA_W-1:0]   dat
  );
    logic [ROB_ID_W-1:0] rq;
    logic [DATA_W-1:0]   rv;
    logic                hit;
    rq  = q;
    rv  = v;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_CDB; i++) begin
      if (!hit && (q != '0) && vld[i] && (ids[i*ROB_ID_W +: ROB_ID_W] == q)) begin
        rq  = '0;
        rv  = dat[i*DATA_W +: DATA_W];
        hit = 1'b1;
      end
    end
    return {rq, rv};
  endfunction

  // A full queue never accepts, even when it also dequeues this cycle.
  assign in_ready = rst && (count_q < CNT_W'(DEPTH));

  // Queue bookkeeping, snooping, enqueue and dispatch selection.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    out_d   = out_q;
    strb_d  = '0;
    new_e   = '0;

    head_e  = mem_q[head_q];
    disp_go = (count_q != '0) && !rob_full && (head_e.is_ls ? !ls_full : !rs_full) && !rollback;
    enq_go  = in_valid && in_ready && !rollback && (in_opnum != '0);

    new_e.opnum       = in_opnum;
    new_e.rd          = in_rd;
    new_e.imm         = in_imm;
    new_e.pc          = in_pc;
    new_e.rollback_pc = in_rollback_pc;
    new_e.is_jump     = in_is_jump;
    new_e.is_ls       = in_is_ls;
    new_e.pred_jump   = in_pred_jump;
    {new_e.q1, new_e.v1} = snoop(in_Q1, in_V1, cdb_valid, cdb_rob_id, cdb_data);
    {new_e.q2, new_e.v2} = snoop(in_Q2, in_V2, cdb_valid, cdb_rob_id, cdb_data);

    if (rollback) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        {mem_d[i].q1, mem_d[i].v1} = snoop(mem_q[i].q1, mem_q[i].v1, cdb_valid, cdb_rob_id, cdb_data);
        {mem_d[i].q2, mem_d[i].v2} = snoop(mem_q[i].q2, mem_q[i].v2, cdb_valid, cdb_rob_id, cdb_data);
      end

      if (disp_go) begin
        out_d.opnum       = head_e.opnum;
        out_d.rd          = head_e.rd;
        out_d.imm         = head_e.imm;
        out_d.pc          = head_e.pc;
        out_d.rollback_pc = head_e.rollback_pc;
        out_d.is_jump     = head_e.is_jump;
        out_d.pred_jump   = head_e.pred_jump;
        out_d.q1          = mem_d[head_q].q1;
        out_d.v1          = mem_d[head_q].v1;
        out_d.q2          = mem_d[head_q].q2;
        out_d.v2          = mem_d[head_q].v2;
        out_d.rob_id      = in_rob_id;
        strb_d            = {1'b1, 1'b1, !head_e.is_ls, head_e.is_ls};
        head_d            = head_q + 1'b1;
      end

      if (enq_go) begin
        mem_d[tail_q] = new_e;
        tail_d        = tail_q + 1'b1;
      end

      count_d = count_q + CNT_W'(enq_go) - CNT_W'(disp_go);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      strb_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
      strb_q  <= strb_d;
    end
  end

  assign {rob_en, reg_en, rs_en, ls_en} = strb_q;
  assign out_opnum       = out_q.opnum;
  assign out_rd          = out_q.rd;
  assign out_imm         = out_q.imm;
  assign out_pc          = out_q.pc;
  assign out_rollback_pc = out_q.rollback_pc;
  assign out_is_jump     = out_q.is_jump;
  assign out_pred_jump   = out_q.pred_jump;
  assign out_Q1          = out_q.q1;
  assign out_Q2          = out_q.q2;
  assign out_V1          = out_q.v1;
  assign out_V2          = out_q.v2;
  assign out_rob_id      = out_q.rob_id;

`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] dispatch_cnt_q, dispatch_cnt_d;

  // Performance counters; rollback does not clear them.
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    dispatch_cnt_d = dispatch_cnt_q;
    if ((count_q != '0) && !rollback && !disp_go) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (disp_go) begin
      dispatch_cnt_d = dispatch_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q    <= '0;
      dispatch_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      dispatch_cnt_q <= dispatch_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign dispatch_cnt = dispatch_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed stimulus with a queue-based reference model checked every cycle.
module tb_dispatch_queue;
  localparam int DEPTH = 4;
  localparam int NCDB  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready;
  logic [5:0]  in_opnum;
  logic [4:0]  in_rd;
  logic [31:0] in_imm, in_pc, in_rollback_pc;
  logic        in_is_jump, in_is_ls, in_pred_jump;
  logic [3:0]  in_Q1, in_Q2, in_rob_id;
  logic [31:0] in_V1, in_V2;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_data;
  logic        rob_full, rs_full, ls_full, rollback;
  logic        rob_en, reg_en, rs_en, ls_en;
  logic [5:0]  out_opnum;
  logic [4:0]  out_rd;
  logic [31:0] out_imm, out_pc, out_rollback_pc;
  logic        out_is_jump, out_pred_jump;
  logic [3:0]  out_Q1, out_Q2, out_rob_id;
  logic [31:0] out_V1, out_V2;
`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_cnt, dispatch_cnt;
`endif

  dispatch_queue #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .ROB_ID_W(4), .DATA_W(32), .OPNUM_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opnum(in_opnum), .in_rd(in_rd), .in_imm(in_imm), .in_pc(in_pc),
    .in_rollback_pc(in_rollback_pc), .in_is_jump(in_is_jump), .in_is_ls(in_is_ls),
    .in_pred_jump(in_pred_jump), .in_Q1(in_Q1), .in_Q2(in_Q2), .in_V1(in_V1), .in_V2(in_V2),
    .in_rob_id(in_rob_id), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .rob_full(rob_full), .rs_full(rs_full), .ls_full(ls_full), .rollback(rollback),
    .rob_en(rob_en), .reg_en(reg_en), .rs_en(rs_en), .ls_en(ls_en),
    .out_opnum(out_opnum), .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc),
    .out_rollback_pc(out_rollback_pc), .out_is_jump(out_is_jump), .out_pred_jump(out_pred_jump),
    .out_Q1(out_Q1), .out_Q2(out_Q2), .out_V1(out_V1), .out_V2(out_V2),
`ifdef DISPATCH_STALL_CNT_EN
    .stall_cnt(stall_cnt), .dispatch_cnt(dispatch_cnt),
`endif
    .out_rob_id(out_rob_id)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  opnum;
    logic [4:0]  rd;
    logic [31:0] imm, pc, rbpc;
    logic        jmp, ls, pj;
    logic [3:0]  q1, q2;
    logic [31:0] v1, v2;
  } ins_t;

  ins_t        mq[$];
  ins_t        e_out;
  logic [3:0]  e_rid;
  logic [3:0]  e_strb;
  logic [31:0] e_scnt, e_dcnt;
  bit          acc;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [35:0] res(input logic [3:0] q, input logic [31:0] v);
    if (q == 4'd0) return {q, v};
    for (int i = 0; i < NCDB; i++) begin
      if (cdb_valid[i] && cdb_rob_id[i*4 +: 4] == q) return {4'd0, cdb_data[i*32 +: 32]};
    end
    return {q, v};
  endfunction

  task automatic model_reset();
    mq.delete();
    e_out  = '{default: '0};
    e_rid  = '0;
    e_strb = '0;
    e_scnt = '0;
    e_dcnt = '0;
  endtask

  // Reference behaviour for the upcoming clock edge, from the inputs now applied.
  task automatic model_step();
    bit   space, disp;
    ins_t h, n;
    acc = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    space  = mq.size() < DEPTH;
    e_strb = '0;
    if (rollback) begin
      mq.delete();
      return;
    end
    disp = (mq.size() > 0) && !rob_full && (mq[0].ls ? !ls_full : !rs_full);
    if (disp) begin
      h = mq.pop_front();
      {h.q1, h.v1} = res(h.q1, h.v1);
      {h.q2, h.v2} = res(h.q2, h.v2);
      e_out  = h;
      e_rid  = in_rob_id;
      e_strb = {2'b11, !h.ls, h.ls};
      e_dcnt = e_dcnt + 1;
    end else if (mq.size() > 0) begin
      e_scnt = e_scnt + 1;
    end
    for (int k = 0; k < mq.size(); k++) begin
      h = mq[k];
      {h.q1, h.v1} = res(h.q1, h.v1);
      {h.q2, h.v2} = res(h.q2, h.v2);
      mq[k] = h;
    end
    if (in_valid && space) begin
      acc = 1;
      if (in_opnum != 6'd0) begin
        n.opnum = in_opnum; n.rd = in_rd; n.imm = in_imm; n.pc = in_pc;
        n.rbpc = in_rollback_pc; n.jmp = in_is_jump; n.ls = in_is_ls; n.pj = in_pred_jump;
        {n.q1, n.v1} = res(in_Q1, in_V1);
        {n.q2, n.v2} = res(in_Q2, in_V2);
        mq.push_back(n);
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", in_ready, rst && (mq.size() < DEPTH));
    chk("strobes", {rob_en, reg_en, rs_en, ls_en}, e_strb);
    chk("fields",
        {out_opnum, out_rd, out_imm, out_pc, out_rollback_pc, out_is_jump, out_pred_jump,
         out_Q1, out_Q2, out_V1, out_V2, out_rob_id},
        {e_out.opnum, e_out.rd, e_out.imm, e_out.pc, e_out.rbpc, e_out.jmp, e_out.pj,
         e_out.q1, e_out.q2, e_out.v1, e_out.v2, e_rid});
`ifdef DISPATCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, e_scnt);
    chk("dispatch_cnt", dispatch_cnt, e_dcnt);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    in_valid = 0; in_opnum = 0; in_rd = 0; in_imm = 0; in_pc = 0; in_rollback_pc = 0;
    in_is_jump = 0; in_is_ls = 0; in_pred_jump = 0; in_Q1 = 0; in_Q2 = 0; in_V1 = 0; in_V2 = 0;
    in_rob_id = 0; cdb_valid = 0; cdb_rob_id = 0; cdb_data = 0;
    rob_full = 0; rs_full = 0; ls_full = 0; rollback = 0;
  endtask

  task automatic offer(input int op, input int rd, input bit ls,
                       input logic [3:0] q1, input logic [31:0] v1,
                       input logic [3:0] q2, input logic [31:0] v2);
    logic [31:0] o;
    o = op;
    in_valid = 1; in_opnum = o[5:0]; in_rd = rd[4:0];
    in_imm = o * 16 + 1; in_pc = 32'h1000 + o * 4; in_rollback_pc = 32'h1004 + o * 4;
    in_is_jump = o[0]; in_pred_jump = o[1]; in_is_ls = ls;
    in_Q1 = q1; in_V1 = v1; in_Q2 = q2; in_V2 = v2;
  endtask

  int   disp_list[$];
  int   exp_ord[12] = '{10, 11, 12, 13, 20, 21, 22, 23, 24, 25, 26, 27};
  int   idx, cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 0;
    model_reset();
    tick();
    tick();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_strobes", {rob_en, reg_en, rs_en, ls_en}, 4'b0000);
    chk("rst_opnum", out_opnum, 6'd0);
    rst = 1;

    // Single ALU instruction, minimum latency, one-cycle strobes.
    offer(5, 3, 0, 4'd0, 32'd7, 4'd0, 32'd0);
    in_rob_id = 4'd2;
    tick();
    chk("t1_accept_nostrobe", rob_en, 1'b0);
    in_valid = 0;
    tick();
    chk("t1_strobes", {rob_en, reg_en, rs_en, ls_en}, 4'b1110);
    chk("t1_V1", out_V1, 32'd7);
    chk("t1_rob_id", out_rob_id, 4'd2);
    chk("t1_opnum_rd", {out_opnum, out_rd}, {6'd5, 5'd3});
    tick();
    chk("t1_one_cycle", {rob_en, reg_en, rs_en, ls_en}, 4'b0000);
    chk("t1_hold_V1", out_V1, 32'd7);

    // Load blocked by ls_full; ALU behind it waits in order.
    ls_full = 1;
    offer(3, 1, 1, 4'd0, 32'h30, 4'd0, 32'h31);
    tick();
    offer(4, 2, 0, 4'd0, 32'h40, 4'd0, 32'h41);
    tick();
    in_valid = 0;
    tick();
    chk("t2_blocked", {rob_en, reg_en, rs_en, ls_en}, 4'b0000);
    ls_full = 0;
    tick();
    chk("t2_load", {rob_en, reg_en, rs_en, ls_en}, 4'b1101);
    chk("t2_load_op", out_opnum, 6'd3);
    tick();
    chk("t2_alu", {rob_en, reg_en, rs_en, ls_en}, 4'b1110);
    chk("t2_alu_op", out_opnum, 6'd4);
    tick();

    // rs_full blocks an ALU instruction.
    rs_full = 1;
    offer(9, 9, 0, 4'd0, 32'h9, 4'd0, 32'h9);
    tick();
    in_valid = 0;
    tick();
    chk("rs_blocked", rob_en, 1'b0);
    rs_full = 0;
    tick();
    chk("rs_release", {rob_en, rs_en}, 2'b11);

    // In-queue snoop from channel 1.
    rob_full = 1;
    offer(6, 6, 0, 4'd5, 32'd0, 4'd0, 32'd1);
    tick();
    in_valid = 0;
    tick();
    cdb_valid = 2'b10; cdb_rob_id = {4'd5, 4'd0}; cdb_data = {32'hDEAD, 32'h0};
    tick();
    cdb_valid = 0; cdb_rob_id = 0; cdb_data = 0;
    rob_full = 0;
    tick();
    chk("t3_snoop_Q1", out_Q1, 4'd0);
    chk("t3_snoop_V1", out_V1, 32'hDEAD);
    // Both channels hit the same tag at dispatch; channel 0 wins.
    offer(7, 7, 0, 4'd0, 32'd2, 4'd6, 32'h55);
    tick();
    in_valid = 0;
    cdb_valid = 2'b11; cdb_rob_id = {4'd6, 4'd6}; cdb_data = {32'h2222, 32'h1111};
    tick();
    chk("t3_dup_Q2", out_Q2, 4'd0);
    chk("t3_dup_V2", out_V2, 32'h1111);
    // Snoop on enqueue; unmatched tag stays pending.
    offer(8, 8, 0, 4'd7, 32'd0, 4'd9, 32'd0);
    cdb_valid = 2'b10; cdb_rob_id = {4'd7, 4'd3}; cdb_data = {32'hBEEF, 32'h3333};
    tick();
    in_valid = 0; cdb_valid = 0; cdb_rob_id = 0; cdb_data = 0;
    tick();
    chk("t3_enq_V1", {out_Q1, out_V1}, {4'd0, 32'hBEEF});
    chk("t3_nomatch_Q2", out_Q2, 4'd9);

    // Fill under rob_full, then drain with streaming enqueue across pointer wrap.
    rob_full = 1;
    for (int i = 0; i < 5; i++) begin
      offer(10 + i, i, 0, 4'd0, 32'(100 + i), 4'd0, 32'(200 + i));
      in_rob_id = 4'(i);
      tick();
      if (i == 3) chk("t4_full_ready", in_ready, 1'b0);
    end
    in_valid = 0;
    rob_full = 0;
    idx = 0;
    disp_list.delete();
    for (int c = 0; c < 40 && disp_list.size() < 12; c++) begin
      if (idx < 8) begin
        offer(20 + idx, idx, 0, 4'd0, 32'(300 + idx), 4'd0, 32'(400 + idx));
        in_rob_id = 4'(idx + 5);
      end else begin
        in_valid = 0;
      end
      tick();
      if (acc) idx++;
      if (rob_en) disp_list.push_back(int'(out_opnum));
    end
    in_valid = 0;
    chk("t4_ndisp", disp_list.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t4_order%0d", k), (k < disp_list.size()) ? disp_list[k] : -1, exp_ord[k]);
    end
    tick();

    // Rollback with three queued and one offered; CDB that cycle is ignored.
    rob_full = 1;
    for (int i = 0; i < 3; i++) begin
      offer(30 + i, i, 0, 4'd1, 32'd0, 4'd0, 32'd0);
      tick();
    end
    offer(33, 3, 0, 4'd0, 32'd0, 4'd0, 32'd0);
    rollback = 1;
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd1}; cdb_data = {32'h0, 32'h77};
    tick();
    chk("t5_strobes", {rob_en, reg_en, rs_en, ls_en}, 4'b0000);
    chk("t5_empty_ready", in_ready, 1'b1);
    rollback = 0; in_valid = 0; rob_full = 0; cdb_valid = 0; cdb_rob_id = 0; cdb_data = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rob_en) cnt++;
    end
    chk("t5_no_disp", cnt, 0);

    // Null opcode consumed but never dispatched.
    offer(0, 1, 0, 4'd0, 32'd5, 4'd0, 32'd5);
    tick();
    chk("null_ready", in_ready, 1'b1);
    in_valid = 0;
    tick();
    chk("null_no_disp", rob_en, 1'b0);

    // Fresh reset, stall/dispatch pattern, then asynchronous reset mid-cycle.
    rst = 0;
    tick();
    rst = 1;
    rob_full = 1;
    offer(50, 1, 0, 4'd0, 32'd1, 4'd0, 32'd2);
    tick();
    offer(51, 2, 1, 4'd0, 32'd3, 4'd0, 32'd4);
    tick();
    in_valid = 0;
    tick();
    tick();
    rob_full = 0;
    tick();
    tick();
    chk("m_last_op", {out_opnum, ls_en}, {6'd51, 1'b1});
`ifdef DISPATCH_STALL_CNT_EN
    chk("m_stall_cnt", stall_cnt, 32'd3);
    chk("m_dispatch_cnt", dispatch_cnt, 32'd2);
`endif
    rst = 0;
    #1;
    model_reset();
    compare();
    chk("ar_strobes", {rob_en, reg_en, rs_en, ls_en}, 4'b0000);
    chk("ar_opnum", out_opnum, 6'd0);
    chk("ar_ready", in_ready, 1'b0);
`ifdef DISPATCH_STALL_CNT_EN
    chk("ar_cnts", {stall_cnt, dispatch_cnt}, 64'd0);
`endif
    tick();
    rst = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
